pq_ring_buffer: RTL and testbench



---
 rtl/pq_pkg.sv | 15 +
 rtl/dp_ram.sv | 23 ++
 rtl/pq_clear_seq.sv | 60 ++++++
 rtl/pq_ring_buffer.sv | 140 ++++++++++++++
 tb/tb_pq_ring_buffer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pq_pkg.sv
// Shared types for the rotating bank buffer.
// Holds the clear-sweep states and the bank-pointer width helper.
package pq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SWEEP_ALL = 2'd1,
    SWEEP_ONE = 2'd2
  } sweep_state_e;

  function automatic int ptr_w(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A word written in one cycle is readable in the next.
module dp_ram #(
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [RAM_WIDTH-1:0]  wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [RAM_WIDTH-1:0]  rdata
);

  logic [RAM_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pq_clear_seq.sv
// Clear sequencer: global sweep of all banks or a single-bank sweep.
// Each sweep walks clr_addr over the full bank depth once.
module pq_clear_seq
  import pq_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int PW         = ptr_w(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  sweep_one,
  input  logic [PW-1:0]         start_bank,
  output sweep_state_e          state,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic [PW-1:0]         clr_bank,
  output logic                  busy
);

  sweep_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [PW-1:0]         clr_bank_q, clr_bank_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_bank_d = clr_bank_q;
    // clear restarts any sweep; a running sweep blocks new single sweeps
    if (clear) begin
      state_d    = SWEEP_ALL;
      clr_addr_d = '0;
    end else if (state_q != IDLE) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == '1) state_d = IDLE;
    end else if (sweep_one) begin
      state_d    = SWEEP_ONE;
      clr_addr_d = '0;
      clr_bank_d = start_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
      clr_bank_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_bank_q <= clr_bank_d;
    end
  end

  assign state    = state_q;
  assign clr_addr = clr_addr_q;
  assign clr_bank = clr_bank_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: rtl/pq_ring_buffer.sv
// N-bank rotating buffer: producer fills banks in order, consumer
// drains them in order, with global and per-bank clear sweeps.
module pq_ring_buffer
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_BANKS  = 4,
  parameter int AUTO_CLEAR = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          din,
  input  logic                           wr_done,
  output logic                           wr_ready,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           dout_valid,
  input  logic                           rd_done,
  output logic                           rd_ready,
  input  logic                           clear,
  output logic                           busy,
  output logic [$clog2(NUM_BANKS+1)-1:0] full_cnt
);

  localparam int PW = ptr_w(NUM_BANKS);
  localparam int CW = $clog2(NUM_BANKS+1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_bank_q, rd_bank_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dv_q, dv_d;

  sweep_state_e          state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [PW-1:0]         clr_bank;
  logic wr_acc, wd_acc, rd_acc, rdd_acc;

  logic [DATA_WIDTH-1:0] rdata [NUM_BANKS];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NUM_BANKS-1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_ready = (cnt_q < CW'(NUM_BANKS))
                 && (state != SWEEP_ALL)
                 && !(state == SWEEP_ONE && wr_ptr_q == clr_bank);
  assign rd_ready = (cnt_q != '0) && (state == IDLE);

  assign wr_acc  = wr_en   & wr_ready;
  assign wd_acc  = wr_done & wr_ready;
  assign rd_acc  = rd_en   & rd_ready;
  assign rdd_acc = rd_done & rd_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rd_bank_d = rd_acc ? rd_ptr_q : rd_bank_q;
    dv_d      = rd_acc;
    if (wd_acc)  wr_ptr_d = nxt(wr_ptr_q);
    if (rdd_acc) rd_ptr_d = nxt(rd_ptr_q);
    if (wd_acc && !rdd_acc) cnt_d = cnt_q + 1'b1;
    if (rdd_acc && !wd_acc) cnt_d = cnt_q - 1'b1;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_bank_q <= '0;
      cnt_q     <= '0;
      dv_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_bank_q <= rd_bank_d;
      cnt_q     <= cnt_d;
      dv_q      <= dv_d;
    end
  end

  pq_clear_seq #(
    .NUM_BANKS  (NUM_BANKS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PW         (PW)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .sweep_one  ((AUTO_CLEAR != 0) && rdd_acc),
    .start_bank (rd_ptr_q),
    .state      (state),
    .clr_addr   (clr_addr),
    .clr_bank   (clr_bank),
    .busy       (busy)
  );

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                  sw, we;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd;

    // the sweep steals this bank's write port while it runs
    always_comb begin
      sw = (state == SWEEP_ALL)
        || (state == SWEEP_ONE && clr_bank == PW'(b));
      we = sw || (wr_acc && wr_ptr_q == PW'(b));
      wa = sw ? clr_addr : wr_addr;
      wd = sw ? '0 : din;
    end

    dp_ram #(
      .RAM_WIDTH  (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (wa),
      .wdata (wd),
      .re    (rd_acc && rd_ptr_q == PW'(b)),
      .raddr (rd_addr),
      .rdata (rdata[b])
    );
  end

  assign dout       = rdata[rd_bank_q];
  assign dout_valid = dv_q;
  assign full_cnt   = cnt_q;

endmodule

// File: tb/tb_pq_ring_buffer.sv
// Directed bench for pq_ring_buffer: one instance without and one
// with auto-clear, both driven by the same stimulus.
module tb_pq_ring_buffer;

  logic       clk = 1'b0;
  logic       rst, wr_en, wr_done, rd_en, rd_done, clear;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] din;

  logic       wr_ready0, rd_ready0, dv0, busy0;
  logic [7:0] dout0;
  logic [2:0] cnt0;
  logic       wr_ready1, rd_ready1, dv1, busy1;
  logic [7:0] dout1;
  logic [2:0] cnt1;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pq_ring_buffer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_BANKS(4), .AUTO_CLEAR(0)
  ) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .din(din),
    .wr_done(wr_done), .wr_ready(wr_ready0), .rd_en(rd_en),
    .rd_addr(rd_addr), .dout(dout0), .dout_valid(dv0),
    .rd_done(rd_done), .rd_ready(rd_ready0), .clear(clear),
    .busy(busy0), .full_cnt(cnt0)
  );

  pq_ring_buffer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_BANKS(4), .AUTO_CLEAR(1)
  ) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .din(din),
    .wr_done(wr_done), .wr_ready(wr_ready1), .rd_en(rd_en),
    .rd_addr(rd_addr), .dout(dout1), .dout_valid(dv1),
    .rd_done(rd_done), .rd_ready(rd_ready1), .clear(clear),
    .busy(busy1), .full_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0; clear = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d,
                    input logic done);
    wr_en = 1; wr_addr = a; din = d; wr_done = done;
    tick();
    idle_in();
  endtask

  task automatic fill(input logic [7:0] base);
    for (int a = 0; a < 16; a++)
      wr(4'(a), base + 8'(a), a == 15);
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en = 1; rd_addr = a;
    tick();
    idle_in();
  endtask

  task automatic rdone();
    rd_done = 1;
    tick();
    idle_in();
  endtask

  task automatic wdone();
    wr_done = 1;
    tick();
    idle_in();
  endtask

  initial begin
    idle_in();
    wr_addr = 0; rd_addr = 0; din = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_busy", busy0, 0);
    chk("rst_dv", dv0, 0);
    chk("rst_wr_ready", wr_ready0, 1);
    chk("rst_rd_ready", rd_ready0, 0);
    chk("rst_cnt", cnt0, 0);

    for (int b = 0; b < 4; b++) fill(8'(b * 16));
    chk("fill_cnt", cnt0, 4);
    chk("fill_wr_ready", wr_ready0, 0);
    chk("fill_rd_ready", rd_ready0, 1);

    wr(4'd5, 8'hAA, 1'b1);
    chk("rej_wr_cnt", cnt0, 4);

    rd(4'd5);
    chk("rd_b0a5", dout0, 8'h05);
    chk("rd_b0a5_dv", dv0, 1);
    tick();
    chk("dv_drop", dv0, 0);

    rdone();
    chk("rdone_cnt", cnt0, 3);
    chk("rdone_wr_ready", wr_ready0, 1);
    chk("rdone_rd_ready", rd_ready0, 1);
    rd(4'd3);
    chk("rd_b1a3", dout0, 8'h13);
    wr(4'd3, 8'h77, 1'b1);
    chk("wrap_cnt", cnt0, 4);

    rdone();
    rdone();
    chk("two_rdone_cnt", cnt0, 2);
    wr_en = 1; wr_addr = 0; din = 8'h99; wr_done = 1; rd_done = 1;
    tick();
    idle_in();
    chk("same_cyc_cnt", cnt0, 2);
    rd(4'd3);
    chk("rd_b0a3_new", dout0, 8'h77);
    rd(4'd4);
    chk("rd_b0a4_old", dout0, 8'h04);
    rdone();
    rd(4'd0);
    chk("rd_b1a0_new", dout0, 8'h99);
    rd(4'd1);
    chk("rd_b1a1_old", dout0, 8'h11);
    wr(4'd0, 8'h55, 1'b1);
    rdone();
    rd(4'd0);
    chk("rd_b2a0_new", dout0, 8'h55);

    wdone(); wdone(); wdone();
    chk("refill_cnt", cnt0, 4);
    clear = 1;
    tick();
    idle_in();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("clr_busy_%0d", i),
          {busy0, wr_ready0, rd_ready0}, 3'b100);
      tick();
    end
    chk("clr_done_busy", busy0, 0);
    chk("clr_done_cnt", cnt0, 0);
    chk("clr_done_wr_ready", wr_ready0, 1);
    chk("clr_done_rd_ready", rd_ready0, 0);

    for (int a = 0; a < 16; a++)
      if (a != 7) wr(4'(a), 8'hA0 + 8'(a), a == 15);
    chk("b0_refill_cnt", cnt0, 1);
    rd(4'd7);
    chk("rd_cleared_a7", dout0, 8'h00);
    rd(4'd6);
    chk("rd_refill_a6", dout0, 8'hA6);

    rdone();
    chk("empty_cnt", cnt0, 0);
    rdone();
    chk("empty_rdone_cnt", cnt0, 0);
    chk("empty_rd_ready", rd_ready0, 0);
    wr(4'd2, 8'h3C, 1'b1);
    rd(4'd2);
    chk("rd_b1a2_ptr", dout0, 8'h3C);

    clear = 1;
    tick();
    idle_in();
    tick(); tick();
    chk("mid_sweep_busy", busy0, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_sweep_busy", busy0, 0);
    chk("rst_sweep_wr_ready", wr_ready0, 1);
    chk("rst_sweep_rd_ready", rd_ready0, 0);
    chk("rst_sweep_cnt", cnt0, 0);
    chk("rst_sweep_dv", dv0, 0);
    chk("rst_ac_busy", busy1, 0);

    for (int b = 0; b < 4; b++) fill(8'(b * 16 + 1));
    chk("ac_fill_cnt", cnt1, 4);
    rdone();
    chk("ac_cnt", cnt1, 3);
    chk("noac_busy", busy0, 0);
    chk("noac_wr_ready", wr_ready0, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ac_sweep_%0d", i),
          {busy1, wr_ready1, rd_ready1}, 3'b100);
      tick();
    end
    chk("ac_done", {busy1, wr_ready1, rd_ready1}, 3'b011);
    wdone();
    chk("ac_refill_cnt", cnt1, 4);
    for (int k = 0; k < 3; k++) begin
      rdone();
      repeat (16) tick();
    end
    chk("ac_drain_cnt", cnt1, 1);
    chk("ac_drain_busy", busy1, 0);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk($sformatf("ac_zero_a%0d", a), dout1, 8'h00);
      if (a == 9) chk("noac_b0a9", dout0, 8'h0A);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    nfail++;
    $display("FAIL timeout observed=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $fatal(1, "timeout");
  end

endmodule
